// File: rtl/alu_cmd_issuer.sv
// Issue stage for a combinational ALU: queues {a,b,sel} commands, presents one at a
// time to the ALU, captures the result and hands it downstream over valid/ready.
module alu_cmd_issuer #(
    parameter int DATA_W     = 4,
    parameter int SEL_W      = 3,
    parameter int RES_W      = DATA_W + 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [DATA_W-1:0]               cmd_a,
    input  logic [DATA_W-1:0]               cmd_b,
    input  logic [SEL_W-1:0]                cmd_sel,
    output logic [DATA_W-1:0]               alu_a_out,
    output logic [DATA_W-1:0]               alu_b_out,
    output logic [SEL_W-1:0]                alu_sel_out,
    input  logic [RES_W-1:0]                alu_y_in,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [RES_W-1:0]                res_y,
    output logic [SEL_W-1:0]                res_sel,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [SEL_W-1:0]  sel;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    cmd_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    state_t           r_state;
    cmd_t             r_alu;
    logic             r_res_valid;
    logic [RES_W-1:0] r_res_y;
    logic [SEL_W-1:0] r_res_sel;

    logic w_push;
    logic w_pop;
    logic w_not_empty;
    cmd_t w_in;
    cmd_t w_head;

    // Ready depends only on the registered count, so no input-to-ready path exists.
    assign cmd_ready   = (r_count != FULL_CNT);
    assign w_not_empty = (r_count != '0);
    assign w_push      = cmd_valid && cmd_ready;
    assign w_pop       = w_not_empty &&
                         ((r_state == S_IDLE) || ((r_state == S_HOLD) && res_ready));
    assign w_in        = '{a: cmd_a, b: cmd_b, sel: cmd_sel};
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_alu       <= '0;
            r_res_valid <= 1'b0;
            r_res_y     <= '0;
            r_res_sel   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_alu   <= w_head;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_res_y     <= alu_y_in;
                    r_res_sel   <= r_alu.sel;
                    r_res_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_pop) begin
                            r_alu   <= w_head;
                            r_state <= S_ISSUE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_a_out   = r_alu.a;
    assign alu_b_out   = r_alu.b;
    assign alu_sel_out = r_alu.sel;
    assign res_valid   = r_res_valid;
    assign res_y       = r_res_y;
    assign res_sel     = r_res_sel;
    assign fifo_count  = r_count;
    assign busy        = (r_state != S_IDLE) || w_not_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized scoreboard bench for alu_cmd_issuer with an a+b ALU stub.
module tb_alu_cmd_issuer;

    localparam int DATA_W = 4;
    localparam int SEL_W  = 3;
    localparam int RES_W  = 5;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [SEL_W-1:0]  cmd_sel;
    logic [DATA_W-1:0] alu_a_out;
    logic [DATA_W-1:0] alu_b_out;
    logic [SEL_W-1:0]  alu_sel_out;
    logic [RES_W-1:0]  alu_y_in;
    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  res_y;
    logic [SEL_W-1:0]  res_sel;
    logic [2:0]        fifo_count;
    logic              busy;

    alu_cmd_issuer #(
        .DATA_W(DATA_W), .SEL_W(SEL_W), .RES_W(RES_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_sel_out(alu_sel_out),
        .alu_y_in(alu_y_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_sel(res_sel),
        .fifo_count(fifo_count), .busy(busy)
    );

    // ALU stub: zero-extended sum, independent of select.
    assign alu_y_in = RES_W'(alu_a_out) + RES_W'(alu_b_out);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [RES_W-1:0] y;
        logic [SEL_W-1:0] sel;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             m_e;
    int               n_tests = 0;
    int               n_fail  = 0;
    int               n_res   = 0;
    logic             rand_rdy = 1'b0;
    logic             hold_pend = 1'b0;
    logic [RES_W-1:0] hold_y;
    logic [SEL_W-1:0] hold_sel;

    // Monitor: records accepted commands, checks results in order and hold stability.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    n_tests++;
                    if (!res_valid || res_y !== hold_y || res_sel !== hold_sel) begin
                        n_fail++;
                        $display("FAIL hold_stable: valid=%0b y=%0d sel=%0d, required valid=1 y=%0d sel=%0d",
                                 res_valid, res_y, res_sel, hold_y, hold_sel);
                    end
                end
                n_tests++;
                if (fifo_count > 3'(DEPTH)) begin
                    n_fail++;
                    $display("FAIL fifo_bound: fifo_count=%0d, required <= %0d", fifo_count, DEPTH);
                end
                if (cmd_valid && cmd_ready)
                    exp_q.push_back('{y: RES_W'(cmd_a) + RES_W'(cmd_b), sel: cmd_sel});
                if (res_valid && res_ready) begin
                    n_res++;
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL result_unexpected: got y=%0d sel=%0d, required no result",
                                 res_y, res_sel);
                    end else begin
                        m_e = exp_q.pop_front();
                        if (res_y !== m_e.y || res_sel !== m_e.sel) begin
                            n_fail++;
                            $display("FAIL result: got y=%0d sel=%0d, required y=%0d sel=%0d",
                                     res_y, res_sel, m_e.y, m_e.sel);
                        end
                    end
                end
                hold_pend = res_valid && !res_ready;
                hold_y    = res_y;
                hold_sel  = res_sel;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int a, input int b, input int sel);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_a     = DATA_W'(a);
        cmd_b     = DATA_W'(b);
        cmd_sel   = SEL_W'(sel);
        while (!cmd_ready && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("push_timeout", 0, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check("drain_timeout", n, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_res_valid"}, int'(res_valid), 0);
        check({tag, "_res_y"}, int'(res_y), 0);
        check({tag, "_fifo_count"}, int'(fifo_count), 0);
        check({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int base;
        int cyc;
        logic acc;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; res_ready = 1'b0;
        #3;
        check_reset_state("por");
        check("por_alu_a", int'(alu_a_out), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Single command latency
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_a = 4'd3; cmd_b = 4'd5; cmd_sel = 3'd2;
        tick();
        cmd_valid = 1'b0;
        check("single_cnt_n", int'(fifo_count), 1);
        check("single_rv_n", int'(res_valid), 0);
        tick();
        check("single_alu_a", int'(alu_a_out), 3);
        check("single_alu_b", int'(alu_b_out), 5);
        check("single_alu_sel", int'(alu_sel_out), 2);
        check("single_rv_n1", int'(res_valid), 0);
        tick();
        check("single_rv_n2", int'(res_valid), 1);
        check("single_y", int'(res_y), 8);
        check("single_sel", int'(res_sel), 2);
        tick();
        check("single_rv_n3", int'(res_valid), 0);
        check("single_busy", int'(busy), 0);
        check("single_alu_keep", int'(alu_a_out), 3);

        // Back-pressure: five accepted, sixth stalls
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(i, i, 0);
        cmd_valid = 1'b1; cmd_a = 4'd6; cmd_b = 4'd6; cmd_sel = 3'd0;
        tick();
        check("bp_cmd_ready", int'(cmd_ready), 0);
        check("bp_count", int'(fifo_count), 4);
        check("bp_res_valid", int'(res_valid), 1);
        check("bp_res_y", int'(res_y), 2);
        base = n_res;
        res_ready = 1'b1;
        cyc = 0;
        while (n_res < base + 6 && cyc < 100) begin
            acc = cmd_ready;
            tick();
            cyc++;
            if (acc) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        check("bp_drain_cycles", cyc, 11);
        wait_drain();

        // Wrap / max operands
        base = n_res;
        for (int k = 0; k < 16; k++) push(15, 15, k % 8);
        wait_drain();
        check("wrap_results", n_res - base, 16);

        // Simultaneous push and pop
        res_ready = 1'b0;
        push(1, 1, 1);
        push(2, 2, 2);
        push(3, 3, 3);
        check("sim_count_pre", int'(fifo_count), 2);
        check("sim_hold", int'(res_valid), 1);
        cmd_valid = 1'b1; cmd_a = 4'd4; cmd_b = 4'd4; cmd_sel = 3'd4;
        res_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        check("sim_count_pushpop", int'(fifo_count), 2);
        push(5, 5, 5);
        push(6, 6, 6);
        check("sim_full_count", int'(fifo_count), 4);
        check("sim_full_ready", int'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_a = 4'd7; cmd_b = 4'd7; cmd_sel = 3'd7;
        res_ready = 1'b1;
        tick();
        check("sim_full_pop", int'(fifo_count), 3);
        tick();
        cmd_valid = 1'b0;
        check("sim_refill", int'(fifo_count), 4);
        wait_drain();

        // Reset while holding a result
        res_ready = 1'b0;
        push(3, 5, 0);
        push(1, 1, 1);
        push(2, 2, 2);
        cyc = 0;
        while (!res_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("mid_hold_y", int'(res_y), 8);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        tick();
        check("mid_post_busy", int'(busy), 0);

        // Full sweep with random downstream readiness
        base = n_res;
        rand_rdy = 1'b1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int s = 0; s < 8; s++)
                    push(a, b, s);
        wait_drain();
        rand_rdy = 1'b0;
        res_ready = 1'b1;
        tick();
        check("sweep_results", n_res - base, 2048);
        check("sweep_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
